// File: rtl/cs_y_packer_if.sv
// Byte-packer stream bundle: 10-bit Y word input, flush, and valid/ready byte output.
// The master side drives Y words and byte_ready; the slave side is the packer.
interface cs_y_packer_if;
    logic       y_valid;
    logic [9:0] y_in;
    logic       flush;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       fifo_empty;
    logic       ovf;
    logic       busy;

    modport master (
        output y_valid, y_in, flush, byte_ready,
        input  byte_data, byte_valid, fifo_empty, ovf, busy
    );

    modport slave (
        input  y_valid, y_in, flush, byte_ready,
        output byte_data, byte_valid, fifo_empty, ovf, busy
    );
endinterface

// File: rtl/cs_y_packer.sv
// Buffers 10-bit Y results in a FIFO and packs each group of 4 words into 5 bytes,
// LSB byte first, with flush padding of a partial group.
module cs_y_packer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input logic          clk,
    input logic          reset,
    cs_y_packer_if.slave bus
);

    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    // Input FIFO
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_empty, fifo_full, push, pop;
    logic [9:0]    pop_word;

    // Gather and emit registers
    logic [39:0] gather_q, gather_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [39:0] emit_q, emit_d;
    logic        emit_full_q, emit_full_d;
    logic [2:0]  bcnt_q, bcnt_d;

    logic flush_pend_q, flush_pend_d;
    logic ovf_q, ovf_d;
    logic accept, emit_done, transfer, force_flush;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FullCnt);
    assign accept      = emit_full_q & bus.byte_ready;
    assign emit_done   = accept & (bcnt_q == 3'd4);
    // A full gather moves on as soon as the emit register is free, including the
    // cycle its last byte is taken, so consecutive groups stream without a bubble.
    assign transfer    = (wcnt_q == 3'd4) & (~emit_full_q | emit_done);
    assign force_flush = flush_pend_q & fifo_empty & (wcnt_q != 3'd0) & (wcnt_q != 3'd4);
    assign push        = bus.y_valid & ~fifo_full;
    assign pop         = ~fifo_empty & ((wcnt_q != 3'd4) | transfer);
    assign pop_word    = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.y_in;
    end

    // Gather: transfer clears first so a same-cycle pop lands in slot 0.
    always_comb begin
        gather_d = gather_q;
        wcnt_d   = wcnt_q;
        if (transfer) begin
            gather_d = '0;
            wcnt_d   = '0;
        end
        if (force_flush) wcnt_d = 3'd4;
        if (pop) begin
            case (wcnt_d)
                3'd0:    gather_d[9:0]   = pop_word;
                3'd1:    gather_d[19:10] = pop_word;
                3'd2:    gather_d[29:20] = pop_word;
                3'd3:    gather_d[39:30] = pop_word;
                default: gather_d = gather_d;
            endcase
            wcnt_d = wcnt_d + 3'd1;
        end
    end

    always_comb begin
        emit_d      = emit_q;
        emit_full_d = emit_full_q;
        bcnt_d      = bcnt_q;
        if (accept) bcnt_d = bcnt_q + 3'd1;
        if (emit_done) begin
            emit_d      = '0;
            emit_full_d = 1'b0;
            bcnt_d      = '0;
        end
        if (transfer) begin
            emit_d      = gather_q;
            emit_full_d = 1'b1;
            bcnt_d      = '0;
        end
    end

    // Pending flush resolves once the FIFO has drained into the gather register.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush_pend_q & fifo_empty & (wcnt_q != 3'd4)) flush_pend_d = 1'b0;
        if (bus.flush) flush_pend_d = 1'b1;
        ovf_d = ovf_q | (bus.y_valid & fifo_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gather_q     <= '0;
            wcnt_q       <= '0;
            emit_q       <= '0;
            emit_full_q  <= 1'b0;
            bcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            gather_q     <= gather_d;
            wcnt_q       <= wcnt_d;
            emit_q       <= emit_d;
            emit_full_q  <= emit_full_d;
            bcnt_q       <= bcnt_d;
            flush_pend_q <= flush_pend_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        case (bcnt_q)
            3'd0:    bus.byte_data = emit_q[7:0];
            3'd1:    bus.byte_data = emit_q[15:8];
            3'd2:    bus.byte_data = emit_q[23:16];
            3'd3:    bus.byte_data = emit_q[31:24];
            3'd4:    bus.byte_data = emit_q[39:32];
            default: bus.byte_data = 8'h00;
        endcase
    end

    assign bus.byte_valid = emit_full_q;
    assign bus.fifo_empty = fifo_empty;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = ~fifo_empty | (wcnt_q != 3'd0) | emit_full_q;

endmodule

// File: tb/tb_cs_y_packer.sv
// Bench for cs_y_packer: a word-group packing model predicts the byte stream, checked
// on every accepted byte, plus literal byte expectations and directed corner cases.
module tb_cs_y_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cs_y_packer_if bus ();

    cs_y_packer #(
        .DEPTH (8),
        .AW    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_bytes [$];
    logic [7:0] log_bytes [$];
    logic [9:0] pend      [$];
    logic [9:0] in_w      [2000];

    bit         exact_mode  = 1'b1;
    bit         bubble_mode = 1'b0;
    bit         seen_valid  = 1'b0;
    int         bubble_cnt  = 0;
    bit         prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void model_pack();
        logic [39:0] g;
        g = {pend[3], pend[2], pend[1], pend[0]};
        for (int k = 0; k < 5; k++) exp_bytes.push_back(g[8*k +: 8]);
        pend.delete();
    endfunction

    function automatic void model_word(input logic [9:0] w);
        pend.push_back(w);
        if (pend.size() == 4) model_pack();
    endfunction

    function automatic void model_flush();
        if (pend.size() != 0) begin
            while (pend.size() < 4) pend.push_back(10'h000);
            model_pack();
        end
    endfunction

    // Compare process: checks every accepted byte and stability under backpressure.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
            seen_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(bus.byte_valid), 64'd1);
                check("hold_data", 64'(bus.byte_data), 64'(prev_data));
            end
            if (bus.byte_valid && bus.byte_ready) begin
                log_bytes.push_back(bus.byte_data);
                if (exact_mode) begin
                    if (exp_bytes.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte actual=%0h required=none", bus.byte_data);
                    end else begin
                        check("byte", 64'(bus.byte_data), 64'(exp_bytes.pop_front()));
                    end
                end
            end
            if (bubble_mode) begin
                if (bus.byte_valid) seen_valid = 1'b1;
                else if (seen_valid && exp_bytes.size() != 0) bubble_cnt++;
            end
            prev_stall = bus.byte_valid && !bus.byte_ready;
            prev_data  = bus.byte_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] w, input bit acc);
        bus.y_valid = 1'b1;
        bus.y_in    = w;
        if (acc) model_word(w);
        tick();
    endtask

    task automatic idle();
        bus.y_valid = 1'b0;
        bus.y_in    = 10'h000;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((exp_bytes.size() != 0 || bus.busy) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=busy required=idle", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit1 [5];
        logic [7:0] lit2 [5];
        int base, n;
        bit done, ok;
        lit1 = '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA};
        lit2 = '{8'h23, 8'h01, 8'h00, 8'h00, 8'h00};

        reset          = 1'b0;
        bus.y_valid    = 1'b0;
        bus.y_in       = 10'h000;
        bus.flush      = 1'b0;
        bus.byte_ready = 1'b1;
        repeat (3) tick();
        check("rst_fifo_empty", 64'(bus.fifo_empty), 64'd1);
        check("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
        check("rst_byte_data", 64'(bus.byte_data), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b1;
        tick();

        // 1: one full group, latency and literal bytes
        base = log_bytes.size();
        send(10'h3FF, 1'b1);
        send(10'h000, 1'b1);
        send(10'h155, 1'b1);
        send(10'h2AA, 1'b1);
        idle();
        tick();
        check("t1_latency_early", 64'(bus.byte_valid), 64'd0);
        tick();
        check("t1_latency_valid", 64'(bus.byte_valid), 64'd1);
        wait_drain("t1", 50);
        check("t1_count", 64'(log_bytes.size() - base), 64'd5);
        for (int k = 0; k < 5; k++) check("t1_literal", 64'(log_bytes[base+k]), 64'(lit1[k]));
        check("t1_ovf", 64'(bus.ovf), 64'd0);
        check("t1_busy", 64'(bus.busy), 64'd0);

        // 2: flush of a single word, then a flush with nothing pending
        base = log_bytes.size();
        send(10'h123, 1'b1);
        idle();
        bus.flush = 1'b1;
        model_flush();
        tick();
        bus.flush = 1'b0;
        wait_drain("t2", 50);
        check("t2_count", 64'(log_bytes.size() - base), 64'd5);
        for (int k = 0; k < 5; k++) check("t2_literal", 64'(log_bytes[base+k]), 64'(lit2[k]));
        base = log_bytes.size();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (10) tick();
        check("t2_empty_flush", 64'(log_bytes.size() - base), 64'd0);
        check("t2_empty_valid", 64'(bus.byte_valid), 64'd0);

        // 3: fill all storage under backpressure, overflow on the 17th word
        bus.byte_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(10'((i * 61 + 7) & 1023), i < 16);
        idle();
        tick();
        check("t3_ovf", 64'(bus.ovf), 64'd1);
        check("t3_fifo_full_nonempty", 64'(bus.fifo_empty), 64'd0);
        check("t3_busy", 64'(bus.busy), 64'd1);
        base = log_bytes.size();
        bus.byte_ready = 1'b1;
        wait_drain("t3", 200);
        check("t3_count", 64'(log_bytes.size() - base), 64'd20);

        // 4: alternating ready over two groups, no bubble between groups
        base        = log_bytes.size();
        bubble_cnt  = 0;
        bubble_mode = 1'b1;
        done        = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (i < 8) begin
                bus.y_valid = 1'b1;
                bus.y_in    = 10'((i * 97 + 5) & 1023);
                model_word(bus.y_in);
            end else begin
                idle();
            end
            bus.byte_ready = (i % 2 == 0);
            tick();
            if (i >= 8 && exp_bytes.size() == 0 && !bus.busy) done = 1'b1;
        end
        bubble_mode    = 1'b0;
        bus.byte_ready = 1'b1;
        check("t4_done", 64'(done), 64'd1);
        check("t4_count", 64'(log_bytes.size() - base), 64'd10);
        check("t4_bubbles", 64'(bubble_cnt), 64'd0);

        // 5: reset while byte 2 of a group is presented
        send(10'h0F0, 1'b1);
        send(10'h30C, 1'b1);
        send(10'h1E1, 1'b1);
        send(10'h2D2, 1'b1);
        idle();
        n = 0;
        while (!bus.byte_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        check("t5_emitting", 64'(bus.byte_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 64'(bus.byte_valid), 64'd0);
        check("t5_rst_ovf", 64'(bus.ovf), 64'd0);
        check("t5_rst_busy", 64'(bus.busy), 64'd0);
        check("t5_rst_empty", 64'(bus.fifo_empty), 64'd1);
        check("t5_rst_data", 64'(bus.byte_data), 64'd0);
        exp_bytes.delete();
        pend.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        base = log_bytes.size();
        send(10'h001, 1'b1);
        send(10'h3FE, 1'b1);
        send(10'h200, 1'b1);
        send(10'h0AB, 1'b1);
        idle();
        wait_drain("t5", 50);
        check("t5_count", 64'(log_bytes.size() - base), 64'd5);

        // 6: saturating input; output must be an in-order subsequence of the input
        exact_mode = 1'b0;
        base = log_bytes.size();
        for (int i = 0; i < 2000; i++) begin
            in_w[i] = 10'(i & 1023);
            bus.y_valid = 1'b1;
            bus.y_in    = in_w[i];
            tick();
        end
        idle();
        repeat (100) tick();
        check("t6_ovf", 64'(bus.ovf), 64'd1);
        check("t6_drained_valid", 64'(bus.byte_valid), 64'd0);
        check("t6_drained_fifo", 64'(bus.fifo_empty), 64'd1);
        n = log_bytes.size() - base;
        check("t6_whole_groups", 64'(n % 5), 64'd0);
        check("t6_enough", 64'(n / 5 * 4 >= 1500), 64'd1);
        ok = 1'b1;
        begin
            int j = 0;
            for (int g = 0; g + 5 <= n; g += 5) begin
                logic [39:0] grp;
                grp = {log_bytes[base+g+4], log_bytes[base+g+3], log_bytes[base+g+2],
                       log_bytes[base+g+1], log_bytes[base+g]};
                for (int s = 0; s < 4; s++) begin
                    while (j < 2000 && in_w[j] != grp[10*s +: 10]) j++;
                    if (j >= 2000) ok = 1'b0;
                    else j++;
                end
            end
        end
        check("t6_subsequence", 64'(ok), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
